// File: rtl/mmm_pkg.sv
// mmm_pkg: core-wide shared constants.
//   XLEN : architectural address / PC width in bits.
package mmm_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Arbitrates front-end redirect requests (exception, branch mispredict,
//   predicted-taken branch) and holds the winning redirect until the PC-gen
//   stage accepts it. It also maintains the front-end flush epoch: a request
//   tagged with a stale epoch belongs to squashed work and is ignored.
//
// Ports
//   clk_i            in   clock, all state updates on rising edge
//   rst_i            in   synchronous active-high reset
//   except_valid_i   in   exception redirect request (always eligible)
//   except_pc_i      in   exception handler target
//   misp_valid_i     in   mispredict redirect request
//   misp_target_i    in   corrected target
//   misp_epoch_i     in   epoch tag of the mispredicting branch
//   pred_valid_i     in   predicted-taken redirect request
//   pred_target_i    in   predicted target
//   pred_epoch_i     in   epoch tag of the prediction
//   redirect_ready_i in   PC gen accepts the pending redirect
//   redirect_valid_o out  redirect pending toward PC gen
//   redirect_pc_o    out  redirect target
//   redirect_src_o   out  00 none, 01 pred, 10 misp, 11 exc
//   flush_o          out  one-cycle squash pulse after every epoch bump
//   epoch_o          out  current epoch
//
// Handshake: a redirect transfers on a rising edge where redirect_valid_o
// and redirect_ready_i are both 1. While valid is high the target may only
// change by pre-emption from a strictly higher priority source. Ready is
// don't-care while valid is low.
module pc_redirect_ctrl
  import mmm_pkg::*;
#(
  parameter int EPOCH_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               except_valid_i,
  input  logic [XLEN-1:0]    except_pc_i,
  input  logic               misp_valid_i,
  input  logic [XLEN-1:0]    misp_target_i,
  input  logic [EPOCH_W-1:0] misp_epoch_i,
  input  logic               pred_valid_i,
  input  logic [XLEN-1:0]    pred_target_i,
  input  logic [EPOCH_W-1:0] pred_epoch_i,
  input  logic               redirect_ready_i,
  output logic               redirect_valid_o,
  output logic [XLEN-1:0]    redirect_pc_o,
  output logic [1:0]         redirect_src_o,
  output logic               flush_o,
  output logic [EPOCH_W-1:0] epoch_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_PRED = 2'b01;
  localparam logic [1:0] SRC_MISP = 2'b10;
  localparam logic [1:0] SRC_EXC  = 2'b11;

  logic [0:0]         state_q;
  logic [XLEN-1:0]    pc_q;
  logic [1:0]         src_q;
  logic               flush_q;
  logic [EPOCH_W-1:0] epoch_q;

  // Eligibility uses the current (pre-increment) epoch.
  logic misp_elig;
  logic pred_elig;
  assign misp_elig = misp_valid_i && (misp_epoch_i == epoch_q);
  assign pred_elig = pred_valid_i && (pred_epoch_i == epoch_q);

  // Highest-priority eligible request this cycle. Source encoding doubles
  // as the priority rank, so pre-emption is a plain magnitude compare.
  logic [1:0]      win_src;
  logic [XLEN-1:0] win_pc;

  always_comb begin
    win_src = SRC_NONE;
    win_pc  = '0;
    if (except_valid_i) begin
      win_src = SRC_EXC;
      win_pc  = except_pc_i;
    end else if (misp_elig) begin
      win_src = SRC_MISP;
      win_pc  = misp_target_i;
    end else if (pred_elig) begin
      win_src = SRC_PRED;
      win_pc  = pred_target_i;
    end
  end

  logic have_req;
  logic consumed;
  logic capture;
  assign have_req = (win_src != SRC_NONE);
  assign consumed = (state_q == ST_PEND) && redirect_ready_i;

  always_comb begin
    capture = 1'b0;
    case (state_q)
      ST_IDLE: capture = have_req;
      ST_PEND: capture = consumed ? have_req : (win_src > src_q);
      default: capture = 1'b0;
    endcase
  end

  // Exceptions and mispredicts both squash younger work.
  logic bump_epoch;
  assign bump_epoch = capture && win_src[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      src_q   <= SRC_NONE;
      flush_q <= 1'b0;
      epoch_q <= '0;
    end else begin
      flush_q <= bump_epoch;
      if (bump_epoch) begin
        epoch_q <= epoch_q + 1'b1;
      end
      if (capture) begin
        state_q <= ST_PEND;
        pc_q    <= win_pc;
        src_q   <= win_src;
      end else if (consumed) begin
        // Target is kept so the PC output holds its last value while idle.
        state_q <= ST_IDLE;
        src_q   <= SRC_NONE;
      end
    end
  end

  assign redirect_valid_o = (state_q == ST_PEND);
  assign redirect_pc_o    = pc_q;
  assign redirect_src_o   = src_q;
  assign flush_o          = flush_q;
  assign epoch_o          = epoch_q;

endmodule
